// File: rtl/fwd_bypass_unit.sv
// Operand forwarding and RAW-hazard stall unit for the X stage, backed by a
// DEPTH-entry shadow of the in-flight writers that follow X.
module fwd_bypass_unit #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     inst_x_i,
  input  logic            valid_x_i,
  input  logic            wb_en_x_i,
  input  logic            is_load_x_i,
  input  logic            flush_i,
  input  logic            fwd_en_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] result_x_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] a_operand_o,
  output logic [XLEN-1:0] b_operand_o,
  output logic [3:0]      fwd_a_sel_o,
  output logic [3:0]      fwd_b_sel_o,
  output logic            stall_o,
  output logic [15:0]     stall_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic [3:0]      sel;
    logic            haz;
  } res_t;

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] load_r;
  logic [DEPTH-1:0] ready_r;
  logic [4:0]       rd_r   [DEPTH];
  logic [XLEN-1:0]  data_r [DEPTH];
  logic [15:0]      stall_cnt_r;

  logic [6:0] opcode_s;
  logic [4:0] rd_x_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       elig_a_s;
  logic       elig_b_s;
  logic [3:0] hit_a_s;
  logic [3:0] hit_b_s;
  res_t       res_a_s;
  res_t       res_b_s;
  logic       stall_s;
  logic       unused_s;

  assign opcode_s = inst_x_i[6:0];
  assign rd_x_s   = inst_x_i[11:7];
  assign rs1_s    = inst_x_i[19:15];
  assign rs2_s    = inst_x_i[24:20];
  assign unused_s = ^{inst_x_i[31:25], inst_x_i[14:12]};

  // Returns k+1 for the youngest valid entry writing rs, 0 when none does.
  function automatic logic [3:0] match_sel(input logic [4:0] rs);
    logic [3:0] m;
    m = 4'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      m = (valid_r[k] && (rd_r[k] == rs)) ? 4'(k + 1) : m;
    end
    return m;
  endfunction

  function automatic res_t resolve(input logic [3:0] hit, input logic [XLEN-1:0] rf);
    res_t            r;
    logic            m_ready;
    logic            m_load_now;
    logic [XLEN-1:0] m_data;
    m_ready    = 1'b0;
    m_load_now = 1'b0;
    m_data     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m_ready    = (hit == 4'(k + 1)) ? ready_r[k] : m_ready;
      m_load_now = (hit == 4'(k + 1)) ? (load_r[k] && (k == LOAD_STAGE)) : m_load_now;
      m_data     = (hit == 4'(k + 1)) ? data_r[k] : m_data;
    end
    r.val = rf;
    r.sel = 4'd0;
    r.haz = 1'b0;
    if (hit == 4'd0) begin
      r.haz = 1'b0;
    end else if (!fwd_en_i) begin
      r.haz = 1'b1;
    end else if (m_ready) begin
      r.val = m_data;
      r.sel = hit;
    end else if (m_load_now) begin
      r.val = mem_data_i;
      r.sel = hit;
    end else begin
      r.haz = 1'b1;
    end
    return r;
  endfunction

  // Operand eligibility by opcode: A is sourced by all but LUI/AUIPC/JAL, B only by R/branch/store.
  always_comb begin
    elig_a_s = 1'b1;
    elig_b_s = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: elig_a_s = 1'b0;
      default:                  elig_a_s = 1'b1;
    endcase
    case (opcode_s)
      OP_REG, OP_BRANCH, OP_STORE: elig_b_s = 1'b1;
      default:                     elig_b_s = 1'b0;
    endcase
  end

  // Match and resolve both operands, then derive the zero-latency stall.
  always_comb begin
    hit_a_s = (elig_a_s && (rs1_s != 5'd0)) ? match_sel(rs1_s) : 4'd0;
    hit_b_s = (elig_b_s && (rs2_s != 5'd0)) ? match_sel(rs2_s) : 4'd0;
    res_a_s = resolve(hit_a_s, rs1_data_i);
    res_b_s = resolve(hit_b_s, rs2_data_i);
    stall_s = valid_x_i & ~flush_i & (res_a_s.haz | res_b_s.haz);
  end

  assign a_operand_o = res_a_s.val;
  assign b_operand_o = res_b_s.val;
  assign fwd_a_sel_o = res_a_s.sel;
  assign fwd_b_sel_o = res_b_s.sel;
  assign stall_o     = stall_s;
  assign stall_cnt_o = stall_cnt_r;

  // Shadow pipe: X enters entry 0 (bubble on stall/flush), loads pick up memory data leaving LOAD_STAGE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= '0;
      load_r  <= '0;
      ready_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_r[k]   <= 5'd0;
        data_r[k] <= '0;
      end
    end else begin
      valid_r[0] <= valid_x_i & wb_en_x_i & (rd_x_s != 5'd0) & ~stall_s & ~flush_i;
      rd_r[0]    <= rd_x_s;
      load_r[0]  <= is_load_x_i;
      ready_r[0] <= ~is_load_x_i;
      data_r[0]  <= result_x_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        rd_r[k]    <= rd_r[k-1];
        load_r[k]  <= load_r[k-1];
        if ((k - 1 == LOAD_STAGE) && valid_r[k-1] && load_r[k-1]) begin
          ready_r[k] <= 1'b1;
          data_r[k]  <= mem_data_i;
        end else begin
          ready_r[k] <= ready_r[k-1];
          data_r[k]  <= data_r[k-1];
        end
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
